// File: rtl/axis_demux.sv
// rtl/axis_demux.sv - packet-atomic AXI-Stream demux, tuser destination on the first beat,
// one FWFT FIFO per sink, out-of-range packets dropped and counted.
module axis_demux #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 8,
  parameter int NUM_SINKS  = 2,
  parameter int DEST_LSB   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_tvalid,
  output logic                             s_tready,
  input  logic                             s_tlast,
  input  logic [USER_WIDTH-1:0]            s_tuser,
  input  logic [DATA_WIDTH-1:0]            s_tdata,
  output logic [NUM_SINKS-1:0]             m_tvalid,
  input  logic [NUM_SINKS-1:0]             m_tready,
  output logic [NUM_SINKS-1:0]             m_tlast,
  output logic [USER_WIDTH*NUM_SINKS-1:0]  m_tuser,
  output logic [DATA_WIDTH*NUM_SINKS-1:0]  m_tdata,
  output logic [15:0]                      dropCount
);

  localparam int DW = (NUM_SINKS > 1) ? $clog2(NUM_SINKS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + USER_WIDTH + DATA_WIDTH;
  localparam int NE = 1 << DW;

  generate
    if (NUM_SINKS < 1 || NUM_SINKS > 8) begin : g_bad_num_sinks
      $error("axis_demux: NUM_SINKS must be in 1..8");
    end
    if (DEST_LSB + DW > USER_WIDTH) begin : g_bad_dest_field
      $error("axis_demux: destination field exceeds tuser");
    end
    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
      $error("axis_demux: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {SOP, FWD, DROP} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dest_q, dest_d;
  logic [DW-1:0]   dest_in, wr_dest;
  logic            in_range, accept, fwd_beat, drop_inc;
  logic [NE-1:0]   full_ext;
  logic [NUM_SINKS-1:0] wr_en, rd_en;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic [EW-1:0]   mem_q    [NUM_SINKS][FIFO_DEPTH];
  logic [EW-1:0]   mem_d    [NUM_SINKS][FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q [NUM_SINKS];
  logic [AW-1:0]   wr_ptr_d [NUM_SINKS];
  logic [AW-1:0]   rd_ptr_q [NUM_SINKS];
  logic [AW-1:0]   rd_ptr_d [NUM_SINKS];
  logic [AW:0]     cnt_q    [NUM_SINKS];
  logic [AW:0]     cnt_d    [NUM_SINKS];

  assign dest_in  = s_tuser[DEST_LSB +: DW];
  assign in_range = ({1'b0, dest_in} < (DW+1)'(NUM_SINKS));

  // Padded to a power of two so any dest value indexes it safely.
  always_comb begin
    full_ext = '0;
    for (int i = 0; i < NUM_SINKS; i++) begin
      full_ext[i] = (cnt_q[i] == (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SOP;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    if (accept) begin
      case (state_q)
        SOP: begin
          if (in_range) begin
            dest_d  = dest_in;
            state_d = s_tlast ? SOP : FWD;
          end else begin
            state_d = s_tlast ? SOP : DROP;
          end
        end
        FWD, DROP: if (s_tlast) state_d = SOP;
        default:   state_d = SOP;
      endcase
    end
  end

  always_comb begin
    s_tready = 1'b0;
    wr_dest  = dest_q;
    fwd_beat = 1'b0;
    if (!rst) begin
      case (state_q)
        SOP: begin
          if (in_range) begin
            wr_dest  = dest_in;
            fwd_beat = 1'b1;
            s_tready = !full_ext[dest_in];
          end else begin
            s_tready = 1'b1;
          end
        end
        FWD: begin
          fwd_beat = 1'b1;
          s_tready = !full_ext[dest_q];
        end
        DROP:    s_tready = 1'b1;
        default: s_tready = 1'b0;
      endcase
    end
    accept   = s_tvalid && s_tready;
    drop_inc = accept && (state_q == SOP) && !in_range;
    for (int i = 0; i < NUM_SINKS; i++) begin
      wr_en[i] = accept && fwd_beat && (wr_dest == DW'(i));
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    for (int i = 0; i < NUM_SINKS; i++) begin
      rd_en[i]    = (cnt_q[i] != '0) && m_tready[i];
      wr_ptr_d[i] = wr_ptr_q[i] + AW'(wr_en[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + AW'(rd_en[i]);
      cnt_d[i]    = cnt_q[i] + (AW+1)'(wr_en[i]) - (AW+1)'(rd_en[i]);
      mem_d[i]    = mem_q[i];
      if (wr_en[i]) mem_d[i][wr_ptr_q[i]] = {s_tlast, s_tuser, s_tdata};
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      drop_cnt_q <= '0;
      for (int i = 0; i < NUM_SINKS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < NUM_SINKS; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_SINKS; g++) begin : g_sink
      assign m_tvalid[g] = (cnt_q[g] != '0);
      assign {m_tlast[g], m_tuser[g*USER_WIDTH +: USER_WIDTH], m_tdata[g*DATA_WIDTH +: DATA_WIDTH]} =
        mem_q[g][rd_ptr_q[g]];
    end
  endgenerate

  assign dropCount = drop_cnt_q;

endmodule

// File: tb/tb_axis_demux.sv
// tb/tb_axis_demux.sv - scoreboard bench for axis_demux with three sinks; directed cases
// followed by randomized packets, destinations and sink backpressure.
module tb_axis_demux;
  localparam int NS = 3;
  localparam int UW = 8;
  localparam int DWD = 32;
  localparam int TMO = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                s_tvalid = 1'b0;
  logic                s_tready;
  logic                s_tlast = 1'b0;
  logic [UW-1:0]       s_tuser = '0;
  logic [DWD-1:0]      s_tdata = '0;
  logic [NS-1:0]       m_tvalid, m_tready, m_tlast;
  logic [NS-1:0]       fixed_rdy = '1;
  logic [NS-1:0]       rnd_rdy = '1;
  bit                  rand_rdy = 1'b0;
  logic [UW*NS-1:0]    m_tuser;
  logic [DWD*NS-1:0]   m_tdata;
  logic [15:0]         dropCount;

  assign m_tready = rand_rdy ? rnd_rdy : fixed_rdy;

  axis_demux #(
    .FIFO_DEPTH(8), .DATA_WIDTH(DWD), .USER_WIDTH(UW), .NUM_SINKS(NS), .DEST_LSB(0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tdata(m_tdata),
    .dropCount(dropCount)
  );

  int vectors = 0;
  int miscompares = 0;
  int model_drops = 0;
  int pops [NS];
  int lasts[NS];
  logic [40:0] exp_q[NS][$];
  bit lat_en = 1'b0;
  bit lat_pend = 1'b0;
  int lat_dest = 0;
  logic [31:0] lat_data = '0;

  always @(posedge clk) begin
    #1;
    rnd_rdy = NS'($urandom);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every sink handshake pops that sink's expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (lat_pend) begin
        lat_pend = 1'b0;
        check("latency_valid", 64'(m_tvalid[lat_dest]), 64'd1);
        check("latency_data", 64'(m_tdata[lat_dest*DWD +: DWD]), 64'(lat_data));
      end
      for (int i = 0; i < NS; i++) begin
        if (m_tvalid[i] && m_tready[i]) begin
          pops[i]++;
          if (m_tlast[i]) lasts[i]++;
          if (exp_q[i].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sink%0d_unexpected: got 0x%0h with nothing expected", i,
                     {m_tlast[i], m_tuser[i*UW +: UW], m_tdata[i*DWD +: DWD]});
          end else begin
            check($sformatf("sink%0d_beat", i),
                  64'({m_tlast[i], m_tuser[i*UW +: UW], m_tdata[i*DWD +: DWD]}),
                  64'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [7:0] u, input logic last,
                           input int tgt, input bit first, output int waits);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = last;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      waits++;
      if (waits >= TMO) begin
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: beat 0x%0h not accepted after %0d cycles", d, waits);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    if (tgt < NS) exp_q[tgt].push_back({last, u, d});
    else if (first) model_drops++;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    if (lat_en && tgt < NS) begin
      lat_pend = 1'b1;
      lat_dest = tgt;
      lat_data = d;
    end
  endtask

  // Reference routing: destination is the low field of the first beat's tuser only.
  task automatic send_packet(input logic [7:0] u0, input logic [7:0] urest, input int len,
                             input int n_send, input logic [31:0] base, input int gap,
                             output int waits_total);
    int tgt;
    int w;
    tgt = int'(u0[1:0]);
    waits_total = 0;
    for (int j = 0; j < n_send; j++) begin
      send_beat(base + 32'(j), (j == 0) ? u0 : urest, (j == len - 1), tgt, (j == 0), w);
      waits_total += w;
      if (gap > 0) begin
        repeat ($urandom_range(0, gap)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int left;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
      if (left == 0) break;
    end
    left = exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
    check(name, 64'(left), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int p0, p1, p2, l0, l1;
    logic [7:0] u0, ur;
    for (int i = 0; i < NS; i++) begin
      pops[i] = 0;
      lasts[i] = 0;
    end

    // Reset with a valid beat offered
    s_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_s_tready", 64'(s_tready), 64'd0);
    check("reset_m_tvalid", 64'(m_tvalid), 64'd0);
    check("reset_dropcount", 64'(dropCount), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_tvalid = 1'b0;

    // Routing with one-cycle latency
    lat_en = 1'b1;
    send_packet(8'h01, 8'h01, 4, 4, 32'hA0, 0, w);
    check("routing_p1_stalls", 64'(w), 64'd0);
    send_packet(8'h00, 8'h00, 3, 3, 32'hB0, 0, w);
    lat_en = 1'b0;
    wait_drain("routing_drain");
    check("routing_sink1_count", 64'(pops[1]), 64'd4);
    check("routing_sink0_count", 64'(pops[0]), 64'd3);
    check("routing_dropcount", 64'(dropCount), 64'd0);

    // Mid-packet tuser changes are ignored for routing
    p0 = pops[0];
    send_packet(8'h00, 8'h01, 5, 5, 32'hC0, 0, w);
    wait_drain("midtuser_drain");
    check("midtuser_sink0_count", 64'(pops[0] - p0), 64'd5);

    // Backpressure on sink 0
    fixed_rdy = 3'b110;
    p0 = pops[0];
    l0 = lasts[0];
    for (int j = 0; j < 8; j++) begin
      send_beat(32'(j), 8'h00, 1'b0, 0, (j == 0), w);
      check("bp_fill_stalls", 64'(w), 64'd0);
    end
    s_tvalid = 1'b1;
    s_tdata  = 32'd8;
    s_tuser  = 8'h00;
    s_tlast  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("bp_s_tready_low", 64'(s_tready), 64'd0);
      check("bp_sink1_idle", 64'(m_tvalid[1]), 64'd0);
    end
    @(posedge clk);
    #1;
    fixed_rdy = 3'b111;
    for (int j = 8; j < 12; j++) send_beat(32'(j), 8'h00, (j == 11), 0, 1'b0, w);
    wait_drain("bp_drain");
    check("bp_sink0_count", 64'(pops[0] - p0), 64'd12);
    check("bp_sink0_lasts", 64'(lasts[0] - l0), 64'd1);

    // Out-of-range destination is dropped at full rate
    p2 = pops[2];
    send_packet(8'h03, 8'h03, 3, 3, 32'hD0, 0, w);
    check("drop_stalls", 64'(w), 64'd0);
    send_packet(8'h02, 8'h02, 2, 2, 32'hE0, 0, w);
    wait_drain("drop_drain");
    check("drop_dropcount", 64'(dropCount), 64'(model_drops));
    check("drop_sink2_count", 64'(pops[2] - p2), 64'd2);

    // Alternating single-beat packets
    p0 = pops[0];
    p1 = pops[1];
    l0 = lasts[0];
    l1 = lasts[1];
    for (int k = 0; k < 10; k++) send_packet(8'(k % 2), 8'h00, 1, 1, 32'hF0 + 32'(k), 0, w);
    wait_drain("single_drain");
    check("single_sink0_count", 64'(pops[0] - p0), 64'd5);
    check("single_sink1_count", 64'(pops[1] - p1), 64'd5);
    check("single_sink0_lasts", 64'(lasts[0] - l0), 64'd5);
    check("single_sink1_lasts", 64'(lasts[1] - l1), 64'd5);

    // Reset in the middle of a packet to sink 1, residue held in its FIFO
    fixed_rdy = 3'b101;
    send_packet(8'h01, 8'h01, 4, 2, 32'h100, 0, w);
    rst = 1'b1;
    for (int i = 0; i < NS; i++) exp_q[i].delete();
    model_drops = 0;
    p1 = pops[1];
    @(negedge clk);
    check("midrst_s_tready", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_dropcount", 64'(dropCount), 64'd0);
    @(posedge clk);
    #1;
    fixed_rdy = 3'b111;
    send_packet(8'h00, 8'h00, 2, 2, 32'h200, 0, w);
    wait_drain("midrst_drain");
    repeat (3) @(negedge clk);
    check("midrst_no_residue", 64'(pops[1] - p1), 64'd0);
    @(posedge clk);
    #1;

    // Randomized packets, destinations, gaps and sink readiness
    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      int len;
      u0  = 8'($urandom);
      ur  = 8'($urandom);
      len = $urandom_range(1, 5);
      send_packet(u0, ur, len, len, 32'(n) << 8, 2, w);
    end
    rand_rdy = 1'b0;
    wait_drain("random_drain");
    check("random_dropcount", 64'(dropCount), 64'(model_drops));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
